if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage RV32 pipeline, directly upstream of the decode stage. Owns the fetch PC, runs a single-outstanding-request handshake with instruction memory, and drives the registered Instruction/PC_IF pair that decode latches every cycle. Handles redirects from branch/jump resolution and stalls from the hazard unit, and inserts NOP bubbles whenever no valid instruction is available.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP, 32'h0000_0013, bubble instruction (addi x0,x0,0)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold Instruction/PC_IF/valid_IF (decode not accepting)
- redirect  in  1  taken branch or jump; overrides stall
- redirect_pc  in  32  new fetch target; bits [1:0] forced to 0
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word aligned
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  fetched instruction
- Instruction  out  32  registered instruction to decode
- PC_IF  out  32  registered PC of Instruction
- valid_IF  out  1  Instruction is real (0 = bubble)

## Operation
- Reset values: Instruction=NOP, PC_IF=0, valid_IF=0, imem_req=0, fetch_pc=RESET_PC, state IDLE, kill=0, buffer empty.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: one cycle after reset release, then REQ.
- REQ: imem_req=1, imem_addr=fetch_pc; imem_gnt -> WAIT.
- WAIT: imem_rvalid -> if kill: clear kill, drop data, REQ. Else if stall=0: load Instruction=rdata, PC_IF=fetch_pc, valid_IF=1, fetch_pc+=4, REQ. Else: capture into buffer, HOLD.
- HOLD: stall=0 -> load outputs from buffer, fetch_pc+=4, REQ.
- Output register with no new instruction and stall=0: Instruction=NOP, valid_IF=0, PC_IF unchanged. With stall=1: all three held.
- Redirect (priority over stall and rvalid): next edge Instruction=NOP, valid_IF=0, fetch_pc=redirect_pc&~3. REQ without gnt -> stay REQ, new address; REQ with gnt same cycle, or WAIT -> kill=1, WAIT (in-flight response discarded); HOLD -> buffer dropped, REQ; IDLE -> REQ.
- rvalid in IDLE/REQ/HOLD ignored.
- fetch_pc arithmetic modulo 2^32: 0xFFFF_FFFC + 4 = 0x0000_0000.
- imem_addr stable while imem_req=1 and imem_gnt=0, except on redirect.

## Timing
- Minimum fetch latency: REQ+gnt cycle, rvalid next cycle -> Instruction valid at the following edge; peak throughput one instruction per 2 cycles (single outstanding).
- imem_req and imem_addr are decoded from the state/fetch_pc registers, not from memory inputs.
- Redirect asserted at edge N: bubble visible after N; first target instruction valid no earlier than N+2 (N+3 when a killed response is pending).
- Reset assertion mid-request: all state cleared immediately; outstanding response ignored (memory reset together with the core).

## Structure
- Shared pipeline package: NOP constant, RESET_PC default, if_state enum {IDLE, REQ, WAIT, HOLD}.
- Single module; PC increment, kill flag, and one-entry buffer are too small to warrant sub-modules.

## Test plan
- Reset release, gnt always 1, rvalid one cycle after gnt -> valid_IF pulses with PC_IF 0x0, 0x4, 0x8 every other cycle; NOP between.
- stall=1 for 3 cycles while rvalid returns 0x00500093 -> output held, HOLD entered, instruction delivered on stall release, no fetch lost.
- redirect to 0x100 while in WAIT -> returning data dropped, next valid instruction has PC_IF=0x100.
- redirect and stall simultaneous, redirect_pc=0x203 -> bubble out, fetch from 0x200.
- gnt withheld 4 cycles -> imem_addr stable, imem_req held, valid_IF=0 throughout.
- RESET_PC=0xFFFF_FFFC -> second fetch address 0x0000_0000; reset mid-WAIT -> outputs NOP/0/0 immediately.

Source files
------------

// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Package : if_stage_pkg
// Brief   : Shared pipeline constants and fetch-stage state encoding
// Rev     : 1.0  initial release
// ============================================================================
package if_stage_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } if_state_t;

endpackage
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module : if_stage
// Brief  : RV32 instruction fetch with single-outstanding imem handshake,
//          redirect/stall handling and registered Instruction/PC_IF to decode
// Rev    : 1.0  initial release
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [31:0] PC_IF,
    output logic        valid_IF
);

    if_state_t   r_state, w_state_next;
    logic [31:0] r_fetch_pc, w_fetch_pc_next;
    logic        r_kill, w_kill_next;
    logic [31:0] r_buf, w_buf_next;
    logic [31:0] r_instr, w_instr_next;
    logic [31:0] r_pc, w_pc_next;
    logic        r_valid, w_valid_next;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_tgt;

    assign w_pc_plus4     = r_fetch_pc + 32'd4;
    assign w_redirect_tgt = redirect_pc & ~32'h0000_0003;

    // Memory-facing outputs come only from registers, never from imem inputs.
    assign imem_req    = (r_state == REQ);
    assign imem_addr   = r_fetch_pc;
    assign Instruction = r_instr;
    assign PC_IF       = r_pc;
    assign valid_IF    = r_valid;

    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_kill_next     = r_kill;
        w_buf_next      = r_buf;
        w_pc_next       = r_pc;
        if (stall) begin
            w_instr_next = r_instr;
            w_valid_next = r_valid;
        end else begin
            w_instr_next = NOP;
            w_valid_next = 1'b0;
        end

        if (redirect) begin
            w_instr_next    = NOP;
            w_valid_next    = 1'b0;
            w_fetch_pc_next = w_redirect_tgt;
            case (r_state)
                IDLE: w_state_next = REQ;
                REQ: begin
                    if (imem_gnt) begin
                        w_kill_next  = 1'b1;
                        w_state_next = WAIT;
                    end
                end
                WAIT: begin
                    // A response arriving with the redirect is the in-flight
                    // one: drop it now rather than waiting for one that never comes.
                    if (imem_rvalid) begin
                        w_kill_next  = 1'b0;
                        w_state_next = REQ;
                    end else begin
                        w_kill_next  = 1'b1;
                    end
                end
                HOLD:    w_state_next = REQ;
                default: w_state_next = IDLE;
            endcase
        end else begin
            case (r_state)
                IDLE: w_state_next = REQ;
                REQ: begin
                    if (imem_gnt) begin
                        w_state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (r_kill) begin
                            w_kill_next  = 1'b0;
                            w_state_next = REQ;
                        end else if (!stall) begin
                            w_instr_next    = imem_rdata;
                            w_pc_next       = r_fetch_pc;
                            w_valid_next    = 1'b1;
                            w_fetch_pc_next = w_pc_plus4;
                            w_state_next    = REQ;
                        end else begin
                            w_buf_next   = imem_rdata;
                            w_state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        w_instr_next    = r_buf;
                        w_pc_next       = r_fetch_pc;
                        w_valid_next    = 1'b1;
                        w_fetch_pc_next = w_pc_plus4;
                        w_state_next    = REQ;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_kill     <= 1'b0;
            r_buf      <= NOP;
            r_instr    <= NOP;
            r_pc       <= 32'h0000_0000;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_kill     <= w_kill_next;
            r_buf      <= w_buf_next;
            r_instr    <= w_instr_next;
            r_pc       <= w_pc_next;
            r_valid    <= w_valid_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_if_stage
// Brief  : Randomized scoreboard bench for if_stage against a program-order model
// Rev    : 1.0  initial release
// ============================================================================
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] Instruction;
    logic [31:0] PC_IF;
    logic        valid_IF;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    if_stage #(.RESET_PC(TB_RESET_PC)) dut (
        .clock      (clock),
        .reset      (reset),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .Instruction(Instruction),
        .PC_IF      (PC_IF),
        .valid_IF   (valid_IF)
    );

    // Program image: each word is a fixed function of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h1357_9BD0) | 32'h0000_0003;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard: expected program-order PCs of the instructions decode should see.
    logic [31:0] exp_q[$];
    logic [31:0] next_push_pc;

    task automatic top_up();
        while (exp_q.size() < 16) begin
            exp_q.push_back(next_push_pc);
            next_push_pc = next_push_pc + 32'd4;
        end
    endtask

    task automatic fill(input logic [31:0] start);
        exp_q.delete();
        next_push_pc = start;
        top_up();
    endtask

    // Stimulus / memory model controls
    bit          stim_en  = 1'b0;
    bit          mon_en   = 1'b0;
    bit          mem_slow = 1'b0;
    bit          ovr_en   = 1'b0;
    int          gnt_block = 0;
    bit          mem_pending = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;

    // Driver: samples handshake at negedge, updates model at the edge, drives at edge+1.
    initial begin
        logic        acc, rv_now, rd_now;
        logic [31:0] acc_addr, rpc_now;
        forever begin
            @(negedge clock);
            acc      = imem_req && imem_gnt;
            acc_addr = imem_addr;
            rv_now   = imem_rvalid;
            rd_now   = redirect;
            rpc_now  = redirect_pc;
            @(posedge clock);
            if (!reset) begin
                mem_pending = 1'b0;
                #1;
                imem_rvalid = 1'b0;
                imem_gnt    = 1'b0;
                stall       = 1'b0;
                redirect    = 1'b0;
                continue;
            end
            if (rv_now) mem_pending = 1'b0;
            if (acc) begin
                mem_pending = 1'b1;
                mem_addr    = acc_addr;
                mem_cnt     = mem_slow ? 4 : int'($urandom_range(0, 2));
            end
            if (rd_now) fill(rpc_now & ~32'h3);
            #1;
            if (mem_pending && mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
                if (mem_pending) mem_cnt--;
            end
            if (gnt_block > 0) begin
                imem_gnt = 1'b0;
                gnt_block--;
            end else begin
                imem_gnt = ($urandom_range(0, 3) != 0);
            end
            if (ovr_en) begin
                stall       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = 32'h0000_0203;
                ovr_en      = 1'b0;
            end else begin
                stall       = stim_en && ($urandom_range(0, 3) == 0);
                redirect    = stim_en && ($urandom_range(0, 19) == 0);
                redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                         : $urandom_range(0, 1023);
            end
            top_up();
        end
    end

    // Monitor: checks outputs produced by the edge just passed.
    initial begin
        logic        prev_valid, prev_req, prev_gnt, seen_stall, seen_redirect;
        logic [31:0] prev_instr, prev_pc, prev_addr, exp_pc;
        int          idle;
        prev_valid = 1'b0; prev_req = 1'b0; prev_gnt = 1'b0;
        seen_stall = 1'b0; seen_redirect = 1'b0;
        prev_instr = NOP; prev_pc = 32'h0; prev_addr = 32'h0; idle = 0;
        forever begin
            @(negedge clock);
            if (mon_en && reset) begin
                if (seen_redirect) begin
                    chk("redirect_bubble_valid", {31'b0, valid_IF}, 32'd0);
                    chk("redirect_bubble_instr", Instruction, NOP);
                end else if (seen_stall) begin
                    chk("stall_hold_instr", Instruction, prev_instr);
                    chk("stall_hold_pc", PC_IF, prev_pc);
                    chk("stall_hold_valid", {31'b0, valid_IF}, {31'b0, prev_valid});
                end else if (valid_IF) begin
                    idle = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL scoreboard_empty actual_pc=%h", PC_IF);
                    end else begin
                        exp_pc = exp_q.pop_front();
                        chk("deliver_pc", PC_IF, exp_pc);
                        chk("deliver_instr", Instruction, mem_word(exp_pc));
                    end
                end else begin
                    chk("bubble_instr", Instruction, NOP);
                end
                if (prev_req && !prev_gnt && !seen_redirect) begin
                    chk("req_held", {31'b0, imem_req}, 32'd1);
                    chk("addr_stable", imem_addr, prev_addr);
                end
                idle++;
                if (idle > 200) begin
                    checks++;
                    failures++;
                    $display("FAIL fetch_timeout actual=no_delivery_for_%0d_cycles required=delivery", idle);
                    idle = 0;
                end
            end else begin
                idle = 0;
            end
            prev_valid    = valid_IF;
            prev_instr    = Instruction;
            prev_pc       = PC_IF;
            prev_req      = imem_req;
            prev_gnt      = imem_gnt;
            prev_addr     = imem_addr;
            seen_stall    = stall;
            seen_redirect = redirect;
        end
    end

    initial begin
        int waited;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_instr", Instruction, NOP);
        chk("rst_pc", PC_IF, 32'h0);
        chk("rst_valid", {31'b0, valid_IF}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        fill(TB_RESET_PC);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_no_req", {31'b0, imem_req}, 32'd0);
        @(negedge clock);
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, TB_RESET_PC);
        mon_en  = 1'b1;
        stim_en = 1'b1;
        repeat (1500) @(posedge clock);

        stim_en = 1'b0;
        repeat (10) @(posedge clock);
        gnt_block = 5;
        repeat (20) @(posedge clock);

        ovr_en = 1'b1;
        repeat (30) @(posedge clock);

        // Reset while a response is outstanding.
        mem_slow = 1'b1;
        waited = 0;
        while (!mem_pending && waited < 50) begin
            @(posedge clock);
            waited++;
        end
        checks++;
        if (!mem_pending) begin
            failures++;
            $display("FAIL reach_wait actual=no_outstanding required=outstanding");
        end
        #3;
        reset  = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("midrst_instr", Instruction, NOP);
        chk("midrst_pc", PC_IF, 32'h0);
        chk("midrst_valid", {31'b0, valid_IF}, 32'd0);
        chk("midrst_req", {31'b0, imem_req}, 32'd0);
        chk("midrst_addr", imem_addr, TB_RESET_PC);
        fill(TB_RESET_PC);
        mem_slow = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;
        stim_en = 1'b1;
        repeat (500) @(posedge clock);
        stim_en = 1'b0;
        repeat (20) @(posedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
